// File: rtl/fpu_addsub_requester_pkg.sv
// Shared definitions for the add/sub FPU requester: FSM states, the timeout
// result value and the layout of a queued request entry.
package fpu_addsub_requester_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam logic [31:0] QNAN   = 32'h7FC0_0000;
    localparam int          OPND_W = 32;

    // Queued entries are packed {sub, tag, b, a} with operand A in the LSBs.
    function automatic int entry_width(input int tag_w);
        return 1 + tag_w + 2 * OPND_W;
    endfunction

endpackage

// File: rtl/fpu_req_fifo.sv
// Small in-order request FIFO with asynchronous reset; head data is always
// visible and a pop simply advances the read pointer.
module fpu_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    // Storage needs no reset: count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == (PTR_W + 1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/fpu_addsub_requester.sv
// Initiator side of the add/sub FPU start/ready handshake: queues tagged
// requests, issues them one at a time and returns tagged results with a watchdog.
module fpu_addsub_requester
    import fpu_addsub_requester_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic             req_sub,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_result,
    output logic [TAG_W-1:0] resp_tag,
    output logic             resp_timeout,
    output logic             fpu_start,
    output logic             fpu_add_sub,
    output logic [31:0]      fpu_a,
    output logic [31:0]      fpu_b,
    input  logic             fpu_ready,
    input  logic [31:0]      fpu_result,
    output logic             busy
);

    localparam int ENTRY_W = entry_width(TAG_W);
    localparam int CNT_W   = $clog2(TIMEOUT + 1);

    state_t             state;
    logic [CNT_W-1:0]   wd_cnt;
    logic [TAG_W-1:0]   op_tag;

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] fifo_din;
    logic [ENTRY_W-1:0] fifo_head;

    logic               head_sub;
    logic [TAG_W-1:0]   head_tag;
    logic [31:0]        head_a;
    logic [31:0]        head_b;

    assign req_ready = !fifo_full;
    assign fifo_push = req_valid && req_ready;
    assign fifo_din  = {req_sub, req_tag, req_b, req_a};
    assign {head_sub, head_tag, head_b, head_a} = fifo_head;

    // A pop only ever feeds the operand registers on the way into ISSUE.
    assign fifo_pop = !fifo_empty &&
                      ((state == ST_IDLE) || (state == ST_RESP && resp_ready));

    assign busy = !fifo_empty || (state != ST_IDLE);

    fpu_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            wd_cnt       <= '0;
            op_tag       <= '0;
            fpu_start    <= 1'b0;
            fpu_add_sub  <= 1'b0;
            fpu_a        <= '0;
            fpu_b        <= '0;
            resp_valid   <= 1'b0;
            resp_result  <= '0;
            resp_tag     <= '0;
            resp_timeout <= 1'b0;
        end else begin
            fpu_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (fifo_pop) begin
                        fpu_a       <= head_a;
                        fpu_b       <= head_b;
                        fpu_add_sub <= head_sub;
                        op_tag      <= head_tag;
                        fpu_start   <= 1'b1;
                        state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    wd_cnt <= '0;
                    state  <= ST_WAIT;
                end
                // fpu_ready seen during ISSUE is stale; only WAIT looks at it.
                ST_WAIT: begin
                    if (fpu_ready) begin
                        resp_result  <= fpu_result;
                        resp_tag     <= op_tag;
                        resp_timeout <= 1'b0;
                        resp_valid   <= 1'b1;
                        state        <= ST_RESP;
                    end else if (wd_cnt == CNT_W'(TIMEOUT - 1)) begin
                        resp_result  <= QNAN;
                        resp_tag     <= op_tag;
                        resp_timeout <= 1'b1;
                        resp_valid   <= 1'b1;
                        state        <= ST_RESP;
                    end else begin
                        wd_cnt <= wd_cnt + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        if (fifo_pop) begin
                            fpu_a       <= head_a;
                            fpu_b       <= head_b;
                            fpu_add_sub <= head_sub;
                            op_tag      <= head_tag;
                            fpu_start   <= 1'b1;
                            state       <= ST_ISSUE;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_addsub_requester.sv
// Scoreboard bench for fpu_addsub_requester with a table-driven behavioural FPU
// (latency 3, optional hang) and a decoupled response monitor.
module tb_fpu_addsub_requester;

    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_a;
    logic [31:0]      req_b;
    logic             req_sub;
    logic [TAG_W-1:0] req_tag;
    logic             resp_valid;
    logic             resp_ready;
    logic [31:0]      resp_result;
    logic [TAG_W-1:0] resp_tag;
    logic             resp_timeout;
    logic             fpu_start;
    logic             fpu_add_sub;
    logic [31:0]      fpu_a;
    logic [31:0]      fpu_b;
    logic             fpu_ready;
    logic [31:0]      fpu_result;
    logic             busy;

    typedef struct packed {
        logic [31:0]      result;
        logic [TAG_W-1:0] tag;
        logic             timeout;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   fpu_lat  = 3;
    bit   fpu_hang = 1'b0;
    int   fpu_cnt;

    localparam logic [31:0]      FILL_A   [4] = '{32'h404CCCCD, 32'h3F800000, 32'h40000000, 32'h3F000000};
    localparam logic [31:0]      FILL_B   [4] = '{32'h40933333, 32'h3F800000, 32'h3F800000, 32'h3E800000};
    localparam logic             FILL_SUB [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    localparam logic [TAG_W-1:0] FILL_TAG [4] = '{4'd0, 4'd1, 4'd2, 4'd3};
    localparam logic [31:0]      FILL_RES [4] = '{32'h40F9999A, 32'h40000000, 32'h3F800000, 32'h3F400000};

    fpu_addsub_requester #(
        .DEPTH   (4),
        .TAG_W   (TAG_W),
        .TIMEOUT (64)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_sub      (req_sub),
        .req_tag      (req_tag),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_result  (resp_result),
        .resp_tag     (resp_tag),
        .resp_timeout (resp_timeout),
        .fpu_start    (fpu_start),
        .fpu_add_sub  (fpu_add_sub),
        .fpu_a        (fpu_a),
        .fpu_b        (fpu_b),
        .fpu_ready    (fpu_ready),
        .fpu_result   (fpu_result),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Hand-computed IEEE-754 results for the operand pairs this bench uses.
    function automatic logic [31:0] fpu_ref(input logic [31:0] a, input logic [31:0] b, input logic sub);
        case ({sub, a, b})
            {1'b0, 32'h3F800000, 32'h40000000}: return 32'h40400000;
            {1'b1, 32'hC1200000, 32'hC0800000}: return 32'hC0C00000;
            {1'b0, 32'h404CCCCD, 32'h40933333}: return 32'h40F9999A;
            {1'b0, 32'h3F800000, 32'h3F800000}: return 32'h40000000;
            {1'b1, 32'h40000000, 32'h3F800000}: return 32'h3F800000;
            {1'b0, 32'h3F000000, 32'h3E800000}: return 32'h3F400000;
            default:                            return 32'hDEADBEEF;
        endcase
    endfunction

    // Behavioural FPU: samples on start, raises a level ready fpu_lat cycles later.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fpu_ready  <= 1'b0;
            fpu_result <= 32'h0;
            fpu_cnt    <= 0;
        end else if (fpu_start) begin
            fpu_ready  <= 1'b0;
            fpu_result <= fpu_ref(fpu_a, fpu_b, fpu_add_sub);
            fpu_cnt    <= fpu_hang ? 0 : fpu_lat - 1;
        end else if (fpu_cnt != 0) begin
            fpu_cnt <= fpu_cnt - 1;
            if (fpu_cnt == 1) begin
                fpu_ready <= 1'b1;
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Monitor: every accepted response must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_resp: got tag %0d result %h, want no response", resp_tag, resp_result);
            end else begin
                e = exp_q.pop_front();
                check_output("resp_result",  resp_result,         e.result);
                check_output("resp_tag",     32'(resp_tag),       32'(e.tag));
                check_output("resp_timeout", 32'(resp_timeout),   32'(e.timeout));
            end
        end
    end

    task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b, input logic sub,
                                  input logic [TAG_W-1:0] tag, input logic [31:0] exp_res,
                                  input logic exp_to);
        int n;
        exp_t e;
        n         = 0;
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        req_sub   = sub;
        req_tag   = tag;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!req_ready) begin
            bad++;
            $display("[TB] FAIL req_accept: got req_ready=0 for 200 cycles, want acceptance");
        end else begin
            e.result  = exp_res;
            e.tag     = tag;
            e.timeout = exp_to;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_start(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fpu_start && n < 100);
        check_output("fpu_start_seen", 32'(fpu_start), 32'd1);
    endtask

    task automatic wait_resp(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp_valid && n < 300);
        check_output("resp_valid_seen", 32'(resp_valid), 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || resp_valid) && n < 500);
        check_output("drain_idle", 32'(busy || resp_valid), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got simulation still running, want finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        int n;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_a      = '0;
        req_b      = '0;
        req_sub    = 1'b0;
        req_tag    = '0;
        resp_ready = 1'b1;

        // Reset values
        @(negedge clk);
        check_output("rst_resp_valid",  32'(resp_valid),   32'd0);
        check_output("rst_req_ready",   32'(req_ready),    32'd1);
        check_output("rst_busy",        32'(busy),         32'd0);
        check_output("rst_fpu_start",   32'(fpu_start),    32'd0);
        check_output("rst_resp_result", resp_result,       32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single add: one-cycle start, operands on the bus, response 4 cycles later
        apply_stimulus(32'h3F800000, 32'h40000000, 1'b0, 4'd5, 32'h40400000, 1'b0);
        wait_start(n);
        check_output("single_fpu_a",      fpu_a,             32'h3F800000);
        check_output("single_fpu_b",      fpu_b,             32'h40000000);
        check_output("single_add_sub",    32'(fpu_add_sub),  32'd0);
        @(negedge clk);
        check_output("single_start_once", 32'(fpu_start),    32'd0);
        wait_resp(n);
        check_output("single_latency",    32'(n + 1),        32'd4);
        wait_idle();

        // Subtract: -10.0 - (-4.0) = -6.0
        apply_stimulus(32'hC1200000, 32'hC0800000, 1'b1, 4'd6, 32'hC0C00000, 1'b0);
        wait_start(n);
        check_output("sub_add_sub", 32'(fpu_add_sub), 32'd1);
        check_output("sub_fpu_a",   fpu_a,            32'hC1200000);
        wait_idle();

        // Fill behind a back-pressured response, then release in order
        resp_ready = 1'b0;
        apply_stimulus(32'h3F800000, 32'h40000000, 1'b0, 4'd9, 32'h40400000, 1'b0);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(FILL_A[i], FILL_B[i], FILL_SUB[i], FILL_TAG[i], FILL_RES[i], 1'b0);
        end
        @(negedge clk);
        check_output("fill_req_ready", 32'(req_ready), 32'd0);
        check_output("fill_busy",      32'(busy),      32'd1);
        wait_resp(n);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_output("bp_resp_valid",  32'(resp_valid), 32'd1);
            check_output("bp_resp_result", resp_result,     32'h40400000);
            check_output("bp_resp_tag",    32'(resp_tag),   32'd9);
            check_output("bp_fpu_start",   32'(fpu_start),  32'd0);
        end
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_output("bp_next_start",      32'(fpu_start),  32'd1);
        check_output("bp_valid_dropped",   32'(resp_valid), 32'd0);
        check_output("bp_next_fpu_a",      fpu_a,           32'h404CCCCD);
        wait_idle();

        // Watchdog: hung FPU gives QNAN after 64 WAIT cycles
        fpu_hang = 1'b1;
        apply_stimulus(32'h3F800000, 32'h3F800000, 1'b0, 4'd7, 32'h7FC00000, 1'b1);
        wait_start(n);
        wait_resp(n);
        check_output("timeout_latency", 32'(n), 32'd65);
        wait_idle();
        fpu_hang = 1'b0;
        apply_stimulus(32'h3F000000, 32'h3E800000, 1'b0, 4'd8, 32'h3F400000, 1'b0);
        wait_idle();

        // Reset mid-WAIT with two ops queued: everything is discarded
        fpu_hang = 1'b1;
        apply_stimulus(32'h3F800000, 32'h40000000, 1'b0, 4'd10, 32'h40400000, 1'b0);
        apply_stimulus(32'h3F800000, 32'h3F800000, 1'b0, 4'd11, 32'h40000000, 1'b0);
        apply_stimulus(32'h3F000000, 32'h3E800000, 1'b0, 4'd12, 32'h3F400000, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        exp_q.delete();
        check_output("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
        check_output("mid_rst_req_ready",  32'(req_ready),  32'd1);
        check_output("mid_rst_busy",       32'(busy),       32'd0);
        check_output("mid_rst_fpu_start",  32'(fpu_start),  32'd0);
        check_output("mid_rst_fpu_a",      fpu_a,           32'h0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        fpu_hang = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
        end
        check_output("post_rst_busy",     32'(busy),         32'd0);
        check_output("scoreboard_empty",  32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
